// File: rtl/wind_vec_avg.sv
// Block-averages signed wind vector samples and presents the rounded mean to the
// rectangular-to-polar stage, rate-limited so the CORDIC always finishes before restarting.
module wind_vec_avg #(
  parameter int LOG2_N  = 3,
  parameter int MIN_GAP = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic signed [15:0]  x_in,
  input  logic signed [15:0]  y_in,
  output logic signed [15:0]  X,
  output logic signed [15:0]  Y,
  output logic                validSpeed,
  output logic                overrun
);

  localparam int DATA_W = 16;
  localparam int SUM_W  = DATA_W + LOG2_N + 1;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(2 ** (LOG2_N - 1));
  localparam logic [7:0] GAP_MAX = 8'(MIN_GAP);

  typedef enum logic [1:0] {EMPTY, PENDING, EMIT} state_t;

  state_t                    state, state_nxt;
  logic signed [SUM_W-1:0]   sum_x, sum_y;
  logic signed [SUM_W-1:0]   sum_x_acc, sum_y_acc;
  logic [LOG2_N-1:0]         cnt;
  logic signed [DATA_W-1:0]  pend_x, pend_y;
  logic [7:0]                gap, gap_nxt;
  logic                      pend, pend_nxt;
  logic                      complete, emit;

  // Mean of a full block, rounded half toward +inf; a mean of 16-bit values cannot overflow.
  function automatic logic signed [DATA_W-1:0] round_avg(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] t;
    t = (s + RND) >>> LOG2_N;
    return t[DATA_W-1:0];
  endfunction

  assign sum_x_acc = sum_x + SUM_W'(x_in);
  assign sum_y_acc = sum_y + SUM_W'(y_in);
  assign complete  = sample_valid && (cnt == '1);
  assign pend      = (state != EMPTY);
  assign emit      = (state == EMIT);

  // The state register encodes pend and whether the gap has expired, so EMIT is a pure decode.
  always_comb begin
    pend_nxt  = pend;
    gap_nxt   = gap;
    state_nxt = state;
    if (complete)  pend_nxt = 1'b1;
    else if (emit) pend_nxt = 1'b0;
    if (emit)                gap_nxt = 8'd0;
    else if (gap < GAP_MAX)  gap_nxt = gap + 8'd1;
    if (!pend_nxt)                state_nxt = EMPTY;
    else if (gap_nxt == GAP_MAX)  state_nxt = EMIT;
    else                          state_nxt = PENDING;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      gap        <= GAP_MAX;
      cnt        <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      X          <= '0;
      Y          <= '0;
      validSpeed <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap        <= gap_nxt;
      validSpeed <= emit;
      if (emit) begin
        X <= pend_x;
        Y <= pend_y;
      end
      if (complete) begin
        pend_x <= round_avg(sum_x_acc);
        pend_y <= round_avg(sum_y_acc);
        sum_x  <= '0;
        sum_y  <= '0;
        cnt    <= '0;
        // An emit at this edge consumes the old block, so only a true overwrite is flagged.
        if (pend && !emit) overrun <= 1'b1;
      end else if (sample_valid) begin
        sum_x <= sum_x_acc;
        sum_y <= sum_y_acc;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wind_vec_avg.sv
// Scoreboard bench for wind_vec_avg: a block/gap model queues expected strobes,
// which are popped and compared whenever the DUT raises validSpeed.
module tb_wind_vec_avg;

  localparam int LOG2_N  = 3;
  localparam int MIN_GAP = 24;
  localparam int N       = 1 << LOG2_N;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_in = '0;
  logic signed [15:0] X, Y;
  logic               validSpeed, overrun;

  wind_vec_avg #(.LOG2_N(LOG2_N), .MIN_GAP(MIN_GAP)) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid),
    .x_in(x_in), .y_in(y_in), .X(X), .Y(Y),
    .validSpeed(validSpeed), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct { int x; int y; } exp_t;
  exp_t q[$];

  int msx, msy, mcnt, mpend, mpx, mpy, mgap, movr, mX, mY;
  bit mon_en = 1'b0;

  task automatic model_step();
    bit em, cp;
    if (reset) begin
      msx = 0; msy = 0; mcnt = 0; mpend = 0; mpx = 0; mpy = 0;
      mgap = MIN_GAP; movr = 0; mX = 0; mY = 0;
      q.delete();
    end else begin
      em = (mpend != 0) && (mgap == MIN_GAP);
      cp = sample_valid && (mcnt == N - 1);
      if (em) begin
        q.push_back('{mpx, mpy});
        mX = mpx;
        mY = mpy;
      end
      if (cp) begin
        if (mpend != 0 && !em) movr = 1;
        mpx = (msx + int'(x_in) + N / 2) >>> LOG2_N;
        mpy = (msy + int'(y_in) + N / 2) >>> LOG2_N;
        msx = 0; msy = 0; mcnt = 0; mpend = 1;
      end else if (sample_valid) begin
        msx += int'(x_in);
        msy += int'(y_in);
        mcnt++;
      end
      if (em && !cp) mpend = 0;
      if (em) mgap = 0;
      else if (mgap < MIN_GAP) mgap++;
    end
  endtask

  // Model updates on the rising edge; DUT outputs are sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      if (mon_en) begin
        if (validSpeed) begin
          if (q.size() == 0) check_eq("spurious_strobe", validSpeed, 0);
          else begin
            e = q.pop_front();
            check_eq("strobe_x", X, e.x);
            check_eq("strobe_y", Y, e.y);
          end
        end else if (q.size() != 0) begin
          check_eq("missing_strobe", validSpeed, 1);
          q.delete();
        end
        check_eq("x_hold", X, mX);
        check_eq("y_hold", Y, mY);
        check_eq("overrun", overrun, movr);
      end
    end
  end

  task automatic drive(input bit v, input int x, input int y);
    @(negedge clock);
    sample_valid = v;
    x_in = 16'(x);
    y_in = 16'(y);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    sample_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_X"}, X, 0);
    check_eq({tag, "_Y"}, Y, 0);
    check_eq({tag, "_vs"}, validSpeed, 0);
    check_eq({tag, "_ovr"}, overrun, 0);
  endtask

  task automatic round_block(input int first, input int exp_x, input string tag);
    drive(1'b1, first, 0);
    repeat (N - 1) drive(1'b1, 0, 0);
    idle(30);
    check_eq(tag, X, exp_x);
  endtask

  initial begin
    do_reset();
    mon_en = 1'b1;
    check_zero("rst");

    // Constant block: strobe one edge after the 8th sample.
    repeat (N) drive(1'b1, 1000, -500);
    idle(30);
    check_eq("const_X", X, 1000);
    check_eq("const_Y", Y, -500);

    round_block(1, 0, "round_1");
    round_block(4, 1, "round_4");
    round_block(-4, 0, "round_m4");
    round_block(-5, -1, "round_m5");

    repeat (N) drive(1'b1, 32767, -32768);
    idle(30);
    check_eq("ext_X", X, 32767);
    check_eq("ext_Y", Y, -32768);

    // Continuous input: blocks complete faster than the strobe gap allows.
    do_reset();
    check_zero("rst2");
    for (int b = 1; b <= 8; b++)
      for (int i = 0; i < N; i++)
        drive(1'b1, 100 * b + i, -7 * b - i);
    idle(60);
    check_eq("gap_X", X, 804);
    check_eq("gap_Y", Y, -59);
    check_eq("gap_ovr", overrun, 1);

    // Sparse input: no overrun, strobe after each block.
    do_reset();
    check_zero("rst3");
    for (int i = 0; i < 2 * N; i++) begin
      drive(1'b1, 50 * i, -i);
      idle(9);
    end
    idle(30);
    check_eq("sparse_X", X, 575);
    check_eq("sparse_Y", Y, -11);
    check_eq("sparse_ovr", overrun, 0);

    // Reset mid-block discards the partial sums.
    repeat (5) drive(1'b1, 100, 100);
    do_reset();
    check_zero("rst_mid");
    idle(30);
    check_eq("rst_mid_vs", validSpeed, 0);
    repeat (N) drive(1'b1, 200, 200);
    idle(30);
    check_eq("after_rst_X", X, 200);
    check_eq("after_rst_Y", Y, 200);

    idle(5);
    check_eq("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
